// File: rtl/cache_controller_pkg.sv
// Shared definitions for the cache controller: state encoding, default
// geometry/timeout and a saturating-increment helper for the statistics.
package cache_controller_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 255;
  localparam int TMR_W       = 8;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOOKUP     = 3'd1,
    S_WAIT_HIT   = 3'd2,
    S_MEM_READ   = 3'd3,
    S_FILL       = 3'd4,
    S_WRITE_THRU = 3'd5
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cache_controller_timer.sv
// Memory wait timer: clears while not waiting, counts wait cycles without
// mem_ready, flags the cycle that is the limit-th wait cycle.
module cache_controller_timer
  import cache_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [TMR_W-1:0] limit,
  output logic             expired
);

  logic [TMR_W-1:0] count_q, count_d;

  // clear has priority; saturate instead of wrapping
  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && count_q != '1)
      count_d = count_q + 1'b1;
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // count starts at 0 on the first wait cycle, so limit-1 marks the limit-th one
  assign expired = (count_q == limit - 1'b1);

endmodule

// File: rtl/cache_controller.sv
// Cache/memory sequencer for one CPU data port: read lookup with miss fill,
// write-through writes, memory timeout abort.
// Optional: define CACHE_CTRL_STATS_EN for hit/miss/timeout counters.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] cache_address,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              cache_wcmd,
  input  logic [DATA_W-1:0] cache_rdata,
  input  logic              cache_hit,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]       stat_hits,
  output logic [15:0]       stat_misses,
  output logic [15:0]       stat_timeouts
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  logic              tmr_clr, tmr_en, tmr_expired;

  // no re-accept while the previous retire is still pulsing
  assign accept = (state_q == S_IDLE) && cpu_req && !done_q && !rst;

  assign tmr_clr = !(state_q == S_MEM_READ || state_q == S_WRITE_THRU);
  assign tmr_en  = !tmr_clr && !mem_ready;

  cache_controller_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .limit   (TMR_W'(TIMEOUT)),
    .expired (tmr_expired)
  );

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      fill_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fill_q  <= fill_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // next state; done/err are decided here and appear one cycle later
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fill_d  = fill_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        addr_d  = cpu_addr;
        wdata_d = cpu_wdata;
        state_d = cpu_we ? S_WRITE_THRU : S_LOOKUP;
      end
      S_LOOKUP: state_d = S_WAIT_HIT;
      S_WAIT_HIT: if (cache_hit) begin
        rdata_d = cache_rdata;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        state_d = S_MEM_READ;
      end
      // mem_ready beats the timeout when both land in the same cycle
      S_MEM_READ: if (mem_ready) begin
        fill_d  = mem_rdata;
        state_d = S_FILL;
      end else if (tmr_expired) begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      S_FILL: begin
        rdata_d = fill_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_WRITE_THRU: if (mem_ready) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else if (tmr_expired) begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // cache/memory strobes; the cache write of a store happens in the accept cycle
  always_comb begin
    cache_address = '0;
    cache_wdata   = '0;
    cache_wcmd    = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        cache_address = cpu_addr;
        if (cpu_we) begin
          cache_wcmd  = 1'b1;
          cache_wdata = cpu_wdata;
        end
      end
      S_LOOKUP, S_WAIT_HIT: cache_address = addr_q;
      S_MEM_READ: begin
        cache_address = addr_q;
        mem_rd        = 1'b1;
        mem_addr      = addr_q;
      end
      S_FILL: begin
        cache_address = addr_q;
        cache_wcmd    = 1'b1;
        cache_wdata   = fill_q;
      end
      S_WRITE_THRU: begin
        cache_address = addr_q;
        mem_wr        = 1'b1;
        mem_addr      = addr_q;
        mem_wdata     = wdata_q;
      end
      default: ;
    endcase
    // quiet bus while reset is held, even if the old state was mid-access
    if (rst) begin
      cache_address = '0;
      cache_wdata   = '0;
      cache_wcmd    = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;
  assign cpu_stall = !rst && (accept || state_q != S_IDLE || done_q);

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hits_q, hits_d, misses_q, misses_d, tmo_q, tmo_d;

  // hit/miss counted when the lookup resolves, timeouts on abort
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    tmo_d    = tmo_q;
    if (state_q == S_WAIT_HIT) begin
      if (cache_hit) hits_d   = sat_inc16(hits_q);
      else           misses_d = sat_inc16(misses_q);
    end
    if (err_d) tmo_d = sat_inc16(tmo_q);
  end

  // statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      tmo_q    <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      tmo_q    <= tmo_d;
    end
  end

  assign stat_hits     = hits_q;
  assign stat_misses   = misses_q;
  assign stat_timeouts = tmo_q;
`endif

endmodule
